// File: rtl/regfile_wbq_pkg.sv
// Shared sizes and the queue entry type for the register-file write queue.
// Forwarding of pending data is enabled by defining REGFILE_WBQ_FWD_EN.
package regfile_wbq_pkg;

  localparam int WBQ_DEPTH_DEFAULT = 4;
  localparam int REG_ADDR_W        = 5;
  localparam int DATA_W            = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] regAddr;
    logic [DATA_W-1:0]     data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Bundle of producer, write-port and read-lookup signals around the write queue.
// master = surrounding pipeline/regfile side, slave = the queue itself.
interface regfile_write_queue_if #(
  parameter int DEPTH = regfile_wbq_pkg::WBQ_DEPTH_DEFAULT
) ();
  import regfile_wbq_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [REG_ADDR_W-1:0]   in_reg;
  logic [DATA_W-1:0]       in_data;
  logic                    wb_stall;
  logic                    ctrl_writeEnable;
  logic [REG_ADDR_W-1:0]   ctrl_writeReg;
  logic [DATA_W-1:0]       data_writeReg;
  logic [REG_ADDR_W-1:0]   ctrl_readRegA;
  logic [REG_ADDR_W-1:0]   ctrl_readRegB;
  logic [DATA_W-1:0]       data_readRegA;
  logic [DATA_W-1:0]       data_readRegB;
  logic [DATA_W-1:0]       data_fwdA;
  logic [DATA_W-1:0]       data_fwdB;
  logic                    hazardA;
  logic                    hazardB;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output in_valid, in_reg, in_data, wb_stall,
           ctrl_readRegA, ctrl_readRegB, data_readRegA, data_readRegB,
    input  in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           data_fwdA, data_fwdB, hazardA, hazardB, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_stall,
           ctrl_readRegA, ctrl_readRegB, data_readRegA, data_readRegB,
    output in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           data_fwdA, data_fwdB, hazardA, hazardB, count
  );

endinterface

// File: rtl/regfile_wbq_match.sv
// Searches the valid queue window for a read address; the youngest match wins.
// The data path only exists when REGFILE_WBQ_FWD_EN is defined.
module regfile_wbq_match
  import regfile_wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0]    entryRegs [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] headPtr,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [REG_ADDR_W-1:0]    readReg,
  output logic                     hit
`ifdef REGFILE_WBQ_FWD_EN
 ,input  logic [DATA_W-1:0]        entryData [DEPTH],
  output logic [DATA_W-1:0]        data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Walk from head (oldest) towards tail so a younger match overrides an older one.
  // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
  always_comb begin
    logic [PTR_W-1:0] slot;
    hit = 1'b0;
`ifdef REGFILE_WBQ_FWD_EN
    data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      slot = headPtr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (readReg != '0) && (entryRegs[slot] == readReg)) begin
        hit = 1'b1;
`ifdef REGFILE_WBQ_FWD_EN
        data = entryData[slot];
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// FIFO of pending register writes drained one per cycle onto the regfile write port.
// Define REGFILE_WBQ_FWD_EN to return the youngest pending value on the read ports.
module regfile_write_queue
  import regfile_wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
  input logic                  clock,
  input logic                  ctrl_reset,
  regfile_write_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbq_entry_t            entries   [DEPTH];
  logic [REG_ADDR_W-1:0] entryRegs [DEPTH];
  logic [PTR_W-1:0]      headPtr;
  logic [PTR_W-1:0]      tailPtr;
  logic [CNT_W-1:0]      countQ;
  logic                  inReady;
  logic                  doStore;
  logic                  doDrain;
  logic                  hitA;
  logic                  hitB;
  wbq_entry_t            headEntry;

  // Writes to r0 are accepted but dropped, so they never occupy a slot.
  assign inReady   = !ctrl_reset && (countQ < CNT_W'(DEPTH));
  assign doStore   = bus.in_valid && inReady && (bus.in_reg != '0);
  assign doDrain   = !ctrl_reset && !bus.wb_stall && (countQ != '0);
  assign headEntry = entries[headPtr];

  // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      countQ  <= '0;
    end else begin
      if (doStore) tailPtr <= tailPtr + PTR_W'(1);
      if (doDrain) headPtr <= headPtr + PTR_W'(1);
      if (doStore && !doDrain)      countQ <= countQ + CNT_W'(1);
      else if (!doStore && doDrain) countQ <= countQ - CNT_W'(1);
    end
  end

  // NOTE: storage is not reset; countQ/headPtr define which slots are valid, so stale data is never seen.
  always_ff @(posedge clock) begin
    if (doStore) entries[tailPtr] <= '{regAddr: bus.in_reg, data: bus.in_data};
  end

  assign bus.in_ready         = inReady;
  assign bus.ctrl_writeEnable = doDrain;
  assign bus.ctrl_writeReg    = doDrain ? headEntry.regAddr : '0;
  assign bus.data_writeReg    = doDrain ? headEntry.data    : '0;
  assign bus.count            = countQ;

`ifdef REGFILE_WBQ_FWD_EN
  logic [DATA_W-1:0] entryData [DEPTH];
  logic [DATA_W-1:0] matchDataA;
  logic [DATA_W-1:0] matchDataB;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign entryRegs[i] = entries[i].regAddr;
`ifdef REGFILE_WBQ_FWD_EN
    assign entryData[i] = entries[i].data;
`endif
  end

  regfile_wbq_match #(.DEPTH(DEPTH)) matchA (
    .entryRegs (entryRegs),
    .headPtr   (headPtr),
    .count     (countQ),
    .readReg   (bus.ctrl_readRegA),
    .hit       (hitA)
`ifdef REGFILE_WBQ_FWD_EN
   ,.entryData (entryData),
    .data      (matchDataA)
`endif
  );

  regfile_wbq_match #(.DEPTH(DEPTH)) matchB (
    .entryRegs (entryRegs),
    .headPtr   (headPtr),
    .count     (countQ),
    .readReg   (bus.ctrl_readRegB),
    .hit       (hitB)
`ifdef REGFILE_WBQ_FWD_EN
   ,.entryData (entryData),
    .data      (matchDataB)
`endif
  );

  assign bus.hazardA = hitA;
  assign bus.hazardB = hitB;

`ifdef REGFILE_WBQ_FWD_EN
  assign bus.data_fwdA = hitA ? matchDataA : bus.data_readRegA;
  assign bus.data_fwdB = hitB ? matchDataB : bus.data_readRegB;
`else
  assign bus.data_fwdA = bus.data_readRegA;
  assign bus.data_fwdB = bus.data_readRegB;
`endif

endmodule
